// File: rtl/cam_write_arbiter_if.sv
// rtl/cam_write_arbiter_if.sv - camera pixel inputs and frame-buffer write port bundle
// Optional: CAM_ARB_DROP_CNT_EN adds the per-camera drop counter outputs.
interface cam_write_arbiter_if #(
    parameter int CAM_DATA_WIDTH = 12,
    parameter int CAM_LINE       = 9,
    parameter int CAM_PIXEL      = 10
);
    logic [1:0]                i_mode;
    logic                      i_we_cam0;
    logic [CAM_DATA_WIDTH-1:0] i_data_cam0;
    logic [CAM_LINE-1:0]       i_line_cam0;
    logic [CAM_PIXEL-1:0]      i_pixel_cam0;
    logic                      i_we_cam1;
    logic [CAM_DATA_WIDTH-1:0] i_data_cam1;
    logic [CAM_LINE-1:0]       i_line_cam1;
    logic [CAM_PIXEL-1:0]      i_pixel_cam1;
    logic                      o_we;
    logic [16:0]               o_addr_wr;
    logic [CAM_DATA_WIDTH-1:0] o_data_wr;
    logic [1:0]                o_overflow;
`ifdef CAM_ARB_DROP_CNT_EN
    logic [15:0]               o_drop_cnt0;
    logic [15:0]               o_drop_cnt1;

    modport master (
        output i_mode, i_we_cam0, i_data_cam0, i_line_cam0, i_pixel_cam0,
        output i_we_cam1, i_data_cam1, i_line_cam1, i_pixel_cam1,
        input  o_we, o_addr_wr, o_data_wr, o_overflow, o_drop_cnt0, o_drop_cnt1
    );
    modport slave (
        input  i_mode, i_we_cam0, i_data_cam0, i_line_cam0, i_pixel_cam0,
        input  i_we_cam1, i_data_cam1, i_line_cam1, i_pixel_cam1,
        output o_we, o_addr_wr, o_data_wr, o_overflow, o_drop_cnt0, o_drop_cnt1
    );
`else
    modport master (
        output i_mode, i_we_cam0, i_data_cam0, i_line_cam0, i_pixel_cam0,
        output i_we_cam1, i_data_cam1, i_line_cam1, i_pixel_cam1,
        input  o_we, o_addr_wr, o_data_wr, o_overflow
    );
    modport slave (
        input  i_mode, i_we_cam0, i_data_cam0, i_line_cam0, i_pixel_cam0,
        input  i_we_cam1, i_data_cam1, i_line_cam1, i_pixel_cam1,
        output o_we, o_addr_wr, o_data_wr, o_overflow
    );
`endif
endinterface

// File: rtl/cam_write_arbiter.sv
// rtl/cam_write_arbiter.sv - two-camera round-robin arbiter onto one frame-buffer write port
// Optional: CAM_ARB_DROP_CNT_EN adds saturating per-camera overflow drop counters.
module cam_write_arbiter #(
    parameter int CAM_DATA_WIDTH = 12,
    parameter int CAM_LINE       = 9,
    parameter int CAM_PIXEL      = 10,
    parameter int FB_WIDTH       = 320,
    parameter int FB_DEPTH       = 240,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst,
    cam_write_arbiter_if.slave  bus
);
    localparam int ENTRY_W = 17 + CAM_DATA_WIDTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int HALF    = FB_WIDTH / 2;

    logic                      w_we    [2];
    logic [CAM_DATA_WIDTH-1:0] w_data  [2];
    logic [CAM_LINE-1:0]       w_line  [2];
    logic [CAM_PIXEL-1:0]      w_pixel [2];
    logic [1:0]                w_mode;
    logic [16:0]               w_col   [2];
    logic [16:0]               w_addr  [2];
    logic                      w_keep  [2];
    logic                      w_empty [2];
    logic                      w_full  [2];
    logic                      w_pop   [2];
    logic                      w_push  [2];
    logic                      w_ovf   [2];

    logic [1:0]                r_mode;
    logic                      r_last;
    logic [ENTRY_W-1:0]        r_mem   [2][FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wptr  [2];
    logic [PTR_W-1:0]          r_rptr  [2];
    logic [PTR_W:0]            r_cnt   [2];
    logic                      r_we;
    logic [16:0]               r_addr;
    logic [CAM_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_ovf;

    assign w_we[0]    = bus.i_we_cam0;
    assign w_data[0]  = bus.i_data_cam0;
    assign w_line[0]  = bus.i_line_cam0;
    assign w_pixel[0] = bus.i_pixel_cam0;
    assign w_we[1]    = bus.i_we_cam1;
    assign w_data[1]  = bus.i_data_cam1;
    assign w_line[1]  = bus.i_line_cam1;
    assign w_pixel[1] = bus.i_pixel_cam1;

    // A frame-start pixel on cam0 switches mode for itself and everything after it.
    assign w_mode = (w_we[0] && w_line[0] == '0 && w_pixel[0] == '0) ? bus.i_mode : r_mode;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_col[n]  = '0;
            w_keep[n] = 1'b0;
            w_addr[n] = '0;
            if (w_mode[1]) begin
                w_keep[n] = !w_pixel[n][0] && (17'(w_pixel[n] >> 1) < 17'(HALF));
                w_col[n]  = 17'(w_pixel[n] >> 1) + ((n == 1) ? 17'(HALF) : 17'd0);
            end else begin
                w_keep[n] = (w_mode[0] == n[0]) && (17'(w_pixel[n]) < 17'(FB_WIDTH));
                w_col[n]  = 17'(w_pixel[n]);
            end
            w_keep[n] = w_keep[n] && (17'(w_line[n]) < 17'(FB_DEPTH));
            w_addr[n] = 17'(w_line[n]) * 17'(FB_WIDTH) + w_col[n];
        end
    end

    assign w_empty[0] = (r_cnt[0] == '0);
    assign w_empty[1] = (r_cnt[1] == '0);
    assign w_full[0]  = (r_cnt[0] == (PTR_W+1)'(FIFO_DEPTH));
    assign w_full[1]  = (r_cnt[1] == (PTR_W+1)'(FIFO_DEPTH));

    // r_last: 0 = cam0 granted last, 1 = cam1 granted last.
    assign w_pop[0] = !w_empty[0] && (w_empty[1] || r_last);
    assign w_pop[1] = !w_empty[1] && (w_empty[0] || !r_last);

    assign w_push[0] = w_we[0] && w_keep[0] && (!w_full[0] || w_pop[0]);
    assign w_push[1] = w_we[1] && w_keep[1] && (!w_full[1] || w_pop[1]);
    assign w_ovf[0]  = w_we[0] && w_keep[0] && w_full[0] && !w_pop[0];
    assign w_ovf[1]  = w_we[1] && w_keep[1] && w_full[1] && !w_pop[1];

    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (w_push[n]) r_mem[n][r_wptr[n]] <= {w_addr[n], w_data[n]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 2'b00;
            r_last <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_ovf  <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                r_wptr[n] <= '0;
                r_rptr[n] <= '0;
                r_cnt[n]  <= '0;
            end
        end else begin
            r_mode <= w_mode;
            for (int n = 0; n < 2; n++) begin
                if (w_push[n]) r_wptr[n] <= r_wptr[n] + 1'b1;
                if (w_pop[n])  r_rptr[n] <= r_rptr[n] + 1'b1;
                r_cnt[n] <= r_cnt[n] + (PTR_W+1)'(w_push[n]) - (PTR_W+1)'(w_pop[n]);
                if (w_ovf[n]) r_ovf[n] <= 1'b1;
            end
            r_we <= w_pop[0] | w_pop[1];
            if (w_pop[0]) begin
                {r_addr, r_data} <= r_mem[0][r_rptr[0]];
                r_last           <= 1'b0;
            end else if (w_pop[1]) begin
                {r_addr, r_data} <= r_mem[1][r_rptr[1]];
                r_last           <= 1'b1;
            end
        end
    end

    assign bus.o_we       = r_we;
    assign bus.o_addr_wr  = r_addr;
    assign bus.o_data_wr  = r_data;
    assign bus.o_overflow = r_ovf;

`ifdef CAM_ARB_DROP_CNT_EN
    logic [15:0] r_drop_cnt [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt[0] <= '0;
            r_drop_cnt[1] <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_ovf[n] && r_drop_cnt[n] != 16'hFFFF) r_drop_cnt[n] <= r_drop_cnt[n] + 16'd1;
            end
        end
    end

    assign bus.o_drop_cnt0 = r_drop_cnt[0];
    assign bus.o_drop_cnt1 = r_drop_cnt[1];
`endif
endmodule

// File: tb/tb_cam_write_arbiter.sv
// tb/tb_cam_write_arbiter.sv - directed self-checking bench for cam_write_arbiter
module tb_cam_write_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   nwr;

    always #5 clk = ~clk;

    cam_write_arbiter_if bus ();

    cam_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic we, input int line, input int pix, input int data);
        bus.i_we_cam0    = we;
        bus.i_line_cam0  = 9'(line);
        bus.i_pixel_cam0 = 10'(pix);
        bus.i_data_cam0  = 12'(data);
    endtask

    task automatic set1(input logic we, input int line, input int pix, input int data);
        bus.i_we_cam1    = we;
        bus.i_line_cam1  = 9'(line);
        bus.i_pixel_cam1 = 10'(pix);
        bus.i_data_cam1  = 12'(data);
    endtask

    task automatic idle();
        set0(1'b0, 0, 1, 0);
        set1(1'b0, 0, 1, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_mode = 2'b00;
        idle();
        step();
        step();
        check("rst_we", 32'(bus.o_we), 0);
        check("rst_addr", 32'(bus.o_addr_wr), 0);
        check("rst_data", 32'(bus.o_data_wr), 0);
        check("rst_ovf", 32'(bus.o_overflow), 0);
`ifdef CAM_ARB_DROP_CNT_EN
        check("rst_drop0", 32'(bus.o_drop_cnt0), 0);
        check("rst_drop1", 32'(bus.o_drop_cnt1), 0);
`endif
        rst = 1'b0;

        // single pixel, mode 00
        set0(1'b1, 2, 5, 12'hABC);
        step();
        idle();
        check("t1_lat1_we", 32'(bus.o_we), 0);
        step();
        check("t1_we", 32'(bus.o_we), 1);
        check("t1_addr", 32'(bus.o_addr_wr), 645);
        check("t1_data", 32'(bus.o_data_wr), 32'hABC);
        step();
        check("t1_we_off", 32'(bus.o_we), 0);
        check("t1_addr_hold", 32'(bus.o_addr_wr), 645);

        // side-by-side, simultaneous pushes
        bus.i_mode = 2'b10;
        set0(1'b1, 0, 0, 12'h001);
        step();
        idle();
        step();
        check("t2_frame_start_addr", 32'(bus.o_addr_wr), 0);
        set1(1'b1, 1, 0, 12'h111);
        step();
        idle();
        step();
        check("t2_cam1_we", 32'(bus.o_we), 1);
        check("t2_cam1_addr", 32'(bus.o_addr_wr), 480);
        check("t2_cam1_data", 32'(bus.o_data_wr), 32'h111);
        set0(1'b1, 0, 4, 12'h222);
        set1(1'b1, 0, 4, 12'h333);
        step();
        idle();
        step();
        check("t2_first_addr", 32'(bus.o_addr_wr), 2);
        check("t2_first_data", 32'(bus.o_data_wr), 32'h222);
        step();
        check("t2_second_we", 32'(bus.o_we), 1);
        check("t2_second_addr", 32'(bus.o_addr_wr), 162);
        check("t2_second_data", 32'(bus.o_data_wr), 32'h333);
        step();
        check("t2_done_we", 32'(bus.o_we), 0);

        // range and odd-pixel drops
        set0(1'b1, 240, 0, 12'h444);
        set1(1'b1, 0, 3, 12'h555);
        step();
        set0(1'b1, 0, 320, 12'h666);
        set1(1'b0, 0, 1, 0);
        step();
        idle();
        check("t5_we_a", 32'(bus.o_we), 0);
        step();
        check("t5_we_b", 32'(bus.o_we), 0);
        check("t5_ovf", 32'(bus.o_overflow), 0);

        // both cameras streaming every cycle
        for (int k = 0; k < 20; k++) begin
            set0(1'b1, 1, 2 * k, k);
            set1(1'b1, 1, 2 * k, 12'h800 | k);
            step();
            if (k >= 1) begin
                check($sformatf("t3_we_%0d", k), 32'(bus.o_we), 1);
                check($sformatf("t3_grant_%0d", k), 32'(bus.o_addr_wr >= 17'd480), 32'(k % 2 == 0));
            end
        end
        idle();
        check("t3_ovf", 32'(bus.o_overflow), 3);
`ifdef CAM_ARB_DROP_CNT_EN
        check("t3_drop0", 32'(bus.o_drop_cnt0), 6);
        check("t3_drop1", 32'(bus.o_drop_cnt1), 7);
`endif
        nwr = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.o_we) nwr++;
        end
        check("t3_drain_writes", 32'(nwr), 8);

        // mode change mid-frame
        bus.i_mode = 2'b00;
        set0(1'b1, 0, 0, 12'h055);
        step();
        idle();
        step();
        check("t4_m00_we", 32'(bus.o_we), 1);
        check("t4_m00_data", 32'(bus.o_data_wr), 32'h055);
        bus.i_mode = 2'b01;
        set1(1'b1, 3, 7, 12'h0AA);
        step();
        idle();
        step();
        check("t4_cam1_ignored", 32'(bus.o_we), 0);
        set0(1'b1, 3, 7, 12'h0BB);
        step();
        idle();
        step();
        check("t4_cam0_addr", 32'(bus.o_addr_wr), 967);
        check("t4_cam0_data", 32'(bus.o_data_wr), 32'h0BB);
        set0(1'b1, 0, 0, 12'h0CC);
        step();
        idle();
        step();
        check("t4_latch_pixel_ignored", 32'(bus.o_we), 0);
        set1(1'b1, 3, 7, 12'h0DD);
        step();
        idle();
        step();
        check("t4_cam1_we", 32'(bus.o_we), 1);
        check("t4_cam1_data", 32'(bus.o_data_wr), 32'h0DD);
        set0(1'b1, 3, 8, 12'h0EE);
        step();
        idle();
        step();
        check("t4_cam0_ignored", 32'(bus.o_we), 0);
        check("t4_ovf_sticky", 32'(bus.o_overflow), 3);

        // reset with entries queued
        bus.i_mode = 2'b10;
        set0(1'b1, 0, 0, 12'h101);
        set1(1'b1, 0, 0, 12'h201);
        step();
        set0(1'b1, 0, 2, 12'h102);
        set1(1'b1, 0, 2, 12'h202);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_we", 32'(bus.o_we), 0);
        check("t6_rst_ovf", 32'(bus.o_overflow), 0);
        nwr = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.o_we) nwr++;
        end
        check("t6_no_stale", 32'(nwr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
